vga_pixel_feeder: RTL and testbench

//  Upstream stage of vga_driver: buffers a valid/ready pixel stream in a small FIFO and

---
 rtl/vga_pixel_feeder_pkg.sv | 23 ++
 rtl/vga_pixel_feeder_fifo.sv | 72 +++++++
 rtl/vga_pixel_feeder.sv | 141 ++++++++++++++
 tb/tb_vga_pixel_feeder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pixel_feeder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vga_pixel_feeder_pkg                                         |
// | Description : Shared widths, fill colour and FSM state encoding for the    |
// |               VGA pixel feeder.                                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package vga_pixel_feeder_pkg;

    localparam int          C_DATA_W     = 16;
    localparam int          C_COORD_W    = 11;
    localparam logic [15:0] C_FILL_COLOR = 16'h0000;

    // Feeder frame-alignment states
    typedef enum logic [1:0] {
        ST_WAIT_SOF = 2'd0,
        ST_FILL     = 2'd1,
        ST_STREAM   = 2'd2,
        ST_RESYNC   = 2'd3
    } feeder_state_t;

endpackage
`default_nettype wire

// File: rtl/vga_pixel_feeder_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sync_fifo_flush                                              |
// | Description : Single-clock show-ahead FIFO with synchronous flush and a    |
// |               registered occupancy count.                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sync_fifo_flush #(
    parameter int WIDTH  = 17,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [WIDTH-1:0]  din,
    input  logic              pop,
    output logic [WIDTH-1:0]  head,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level
);

    logic [WIDTH-1:0] r_mem_q [DEPTH];
    logic [ADDR_W:0]  r_wptr_q, w_wptr_d;
    logic [ADDR_W:0]  r_rptr_q, w_rptr_d;
    logic [ADDR_W:0]  r_level_q, w_level_d;

    // Extra pointer MSB distinguishes full from empty when the indices match
    assign empty = (r_wptr_q == r_rptr_q);
    assign full  = (r_wptr_q[ADDR_W] != r_rptr_q[ADDR_W]) &&
                   (r_wptr_q[ADDR_W-1:0] == r_rptr_q[ADDR_W-1:0]);
    assign head  = r_mem_q[r_rptr_q[ADDR_W-1:0]];
    assign level = r_level_q;

    // Next pointer / occupancy values; flush wins over any push or pop
    always_comb begin
        w_wptr_d  = r_wptr_q;
        w_rptr_d  = r_rptr_q;
        w_level_d = r_level_q;
        if (flush) begin
            w_wptr_d  = '0;
            w_rptr_d  = '0;
            w_level_d = '0;
        end else begin
            if (push) w_wptr_d = r_wptr_q + 1'b1;
            if (pop)  w_rptr_d = r_rptr_q + 1'b1;
            w_level_d = r_level_q + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, pop};
        end
    end

    // Pointer and level registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr_q  <= '0;
            r_rptr_q  <= '0;
            r_level_q <= '0;
        end else begin
            r_wptr_q  <= w_wptr_d;
            r_rptr_q  <= w_rptr_d;
            r_level_q <= w_level_d;
        end
    end

    // Storage array, written without reset
    always_ff @(posedge clk) begin
        if (push && !flush) r_mem_q[r_wptr_q[ADDR_W-1:0]] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/vga_pixel_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vga_pixel_feeder                                             |
// | Description : Buffers an SOF-tagged pixel stream and answers vga_driver    |
// |               pixel requests one cycle later, with underflow / SOF error   |
// |               detection and re-lock on the next SOF.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module vga_pixel_feeder
    import vga_pixel_feeder_pkg::*;
#(
    parameter int                DATA_W     = C_DATA_W,
    parameter int                DEPTH      = 64,
    parameter int                ADDR_W     = 6,
    parameter logic [DATA_W-1:0] FILL_COLOR = DATA_W'(C_FILL_COLOR)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_W-1:0]    s_data,
    input  logic                 s_sof,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic                 data_req,
    input  logic [C_COORD_W-1:0] pixel_xpos,
    input  logic [C_COORD_W-1:0] pixel_ypos,
    output logic [DATA_W-1:0]    pixel_data,
    output logic                 err_underflow,
    output logic                 err_sof,
    output logic                 sync_lost,
    output logic [ADDR_W:0]      fifo_level
);

    feeder_state_t     r_state_q, w_state_d;
    logic [DATA_W-1:0] r_pixel_q, w_pixel_d;
    logic              r_err_uf_q, w_err_uf_d;
    logic              r_err_sof_q, w_err_sof_d;

    logic              w_push, w_pop, w_flush;
    logic              w_full, w_empty;
    logic [DATA_W:0]   w_head;
    logic              w_head_sof;
    logic              w_origin;
    logic              w_xfer;

    assign w_head_sof = w_head[DATA_W];
    assign w_origin   = (pixel_xpos == '0) && (pixel_ypos == '0);
    // Held low during reset so nothing is taken while the FIFO is being cleared
    assign s_ready    = !rst && !w_full && (r_state_q != ST_RESYNC);
    assign w_xfer     = s_valid && s_ready;

    sync_fifo_flush #(
        .WIDTH  (DATA_W + 1),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (w_flush),
        .push  (w_push),
        .din   ({s_sof, s_data}),
        .pop   (w_pop),
        .head  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .level (fifo_level)
    );

    // Next-state, FIFO control and output pixel selection
    always_comb begin
        w_state_d   = r_state_q;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_flush     = 1'b0;
        w_err_uf_d  = 1'b0;
        w_err_sof_d = 1'b0;
        case (r_state_q)
            ST_WAIT_SOF: begin
                // Non-SOF beats are accepted but dropped
                if (w_xfer && s_sof) begin
                    w_push    = 1'b1;
                    w_state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                w_push = w_xfer;
                if (data_req && w_origin && !w_empty) begin
                    if (w_head_sof) begin
                        w_pop     = 1'b1;
                        w_state_d = ST_STREAM;
                    end else begin
                        w_err_sof_d = 1'b1;
                        w_state_d   = ST_RESYNC;
                    end
                end
            end
            ST_STREAM: begin
                w_push = w_xfer;
                if (data_req) begin
                    if (w_empty) begin
                        w_err_uf_d = 1'b1;
                        w_state_d  = ST_RESYNC;
                    end else begin
                        w_pop = 1'b1;
                        if (w_head_sof != w_origin) begin
                            w_err_sof_d = 1'b1;
                            w_state_d   = ST_RESYNC;
                        end
                    end
                end
            end
            default: begin
                w_flush   = 1'b1;
                w_state_d = ST_WAIT_SOF;
            end
        endcase
        w_pixel_d = r_pixel_q;
        if (data_req) w_pixel_d = w_pop ? w_head[DATA_W-1:0] : FILL_COLOR;
    end

    // State, output pixel and error pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q   <= ST_WAIT_SOF;
            r_pixel_q   <= FILL_COLOR;
            r_err_uf_q  <= 1'b0;
            r_err_sof_q <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_pixel_q   <= w_pixel_d;
            r_err_uf_q  <= w_err_uf_d;
            r_err_sof_q <= w_err_sof_d;
        end
    end

    assign pixel_data    = r_pixel_q;
    assign err_underflow = r_err_uf_q;
    assign err_sof       = r_err_sof_q;
    assign sync_lost     = (r_state_q != ST_STREAM);

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_vga_pixel_feeder                                          |
// | Description : Directed self-checking bench for vga_pixel_feeder.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_vga_pixel_feeder;

    localparam int C_DEPTH  = 32;
    localparam int C_ADDR_W = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] s_data = '0;
    logic        s_sof = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        data_req = 1'b0;
    logic [10:0] pixel_xpos = '0;
    logic [10:0] pixel_ypos = '0;
    logic [15:0] pixel_data;
    logic        err_underflow;
    logic        err_sof;
    logic        sync_lost;
    logic [C_ADDR_W:0] fifo_level;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    vga_pixel_feeder #(
        .DATA_W     (16),
        .DEPTH      (C_DEPTH),
        .ADDR_W     (C_ADDR_W),
        .FILL_COLOR (16'h0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_data        (s_data),
        .s_sof         (s_sof),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .data_req      (data_req),
        .pixel_xpos    (pixel_xpos),
        .pixel_ypos    (pixel_ypos),
        .pixel_data    (pixel_data),
        .err_underflow (err_underflow),
        .err_sof       (err_sof),
        .sync_lost     (sync_lost),
        .fifo_level    (fifo_level)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d, input logic sof);
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        step();
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic req(input int x, input int y);
        data_req   = 1'b1;
        pixel_xpos = 11'(x);
        pixel_ypos = 11'(y);
        step();
        data_req = 1'b0;
    endtask

    initial begin
        int acc;
        logic rdy;

        // ---- reset state
        repeat (3) step();
        chk("rst_pixel", 32'(pixel_data), 32'h0);
        chk("rst_ready", 32'(s_ready), 32'h0);
        chk("rst_sync_lost", 32'(sync_lost), 32'h1);
        chk("rst_level", 32'(fifo_level), 32'h0);
        chk("rst_errs", {30'h0, err_underflow, err_sof}, 32'h0);
        rst = 1'b0;
        step();
        chk("post_rst_ready", 32'(s_ready), 32'h1);

        // ---- nominal stream
        push(16'h0001, 1'b1);
        for (int i = 2; i <= 16; i++) push(16'(i), 1'b0);
        chk("nom_level", 32'(fifo_level), 32'd16);
        chk("nom_sync_before", 32'(sync_lost), 32'h1);
        req(0, 0);
        chk("nom_pix0", 32'(pixel_data), 32'h0001);
        chk("nom_sync_after", 32'(sync_lost), 32'h0);
        for (int i = 1; i < 16; i++) begin
            req(i, 0);
            chk("nom_pix", 32'(pixel_data), 32'(i + 1));
        end
        chk("nom_hold", 32'(pixel_data), 32'h0010);
        step();
        chk("nom_hold2", 32'(pixel_data), 32'h0010);

        // ---- underflow
        req(16, 0);
        chk("uf_pixel", 32'(pixel_data), 32'h0);
        chk("uf_pulse", 32'(err_underflow), 32'h1);
        chk("uf_no_sof_err", 32'(err_sof), 32'h0);
        chk("uf_resync_ready", 32'(s_ready), 32'h0);
        step();
        chk("uf_pulse_end", 32'(err_underflow), 32'h0);
        chk("uf_level", 32'(fifo_level), 32'h0);
        chk("uf_sync_lost", 32'(sync_lost), 32'h1);
        chk("uf_ready_back", 32'(s_ready), 32'h1);

        // ---- pre-SOF discard
        for (int i = 0; i < 3; i++) push(16'h1111, 1'b0);
        chk("pre_level0", 32'(fifo_level), 32'h0);
        push(16'hA5A5, 1'b1);
        chk("pre_level1", 32'(fifo_level), 32'h1);
        req(3, 0);
        chk("fill_nonorigin_pix", 32'(pixel_data), 32'h0);
        chk("fill_nonorigin_level", 32'(fifo_level), 32'h1);
        req(0, 0);
        chk("pre_pix", 32'(pixel_data), 32'hA5A5);
        chk("pre_sync", 32'(sync_lost), 32'h0);

        // ---- SOF mismatch at (5,0)
        for (int i = 1; i <= 4; i++) push(16'hB000 + 16'(i), 1'b0);
        push(16'h5555, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            req(i, 0);
            chk("sofm_pix", 32'(pixel_data), 32'hB000 + 32'(i));
        end
        chk("sofm_no_err_yet", 32'(err_sof), 32'h0);
        req(5, 0);
        chk("sofm_pix_bad", 32'(pixel_data), 32'h5555);
        chk("sofm_pulse", 32'(err_sof), 32'h1);
        chk("sofm_sync_lost", 32'(sync_lost), 32'h1);
        step();
        chk("sofm_pulse_end", 32'(err_sof), 32'h0);
        chk("sofm_level", 32'(fifo_level), 32'h0);
        push(16'h7777, 1'b1);
        req(0, 0);
        chk("relock_pix", 32'(pixel_data), 32'h7777);
        chk("relock_sync", 32'(sync_lost), 32'h0);

        // ---- backpressure: fill to DEPTH with no requests
        acc = 0;
        s_valid = 1'b1;
        for (int i = 0; i < C_DEPTH + 2; i++) begin
            s_data = 16'hC000 + 16'(acc);
            rdy = s_ready;
            step();
            if (rdy) acc++;
        end
        chk("bp_level_full", 32'(fifo_level), 32'(C_DEPTH));
        chk("bp_ready_low", 32'(s_ready), 32'h0);
        for (int k = 0; k < 4; k++) begin
            data_req   = 1'b1;
            pixel_xpos = 11'(k + 1);
            pixel_ypos = '0;
            s_data     = 16'hC000 + 16'(acc);
            rdy = s_ready;
            step();
            if (rdy) acc++;
            chk("bp_order", 32'(pixel_data), 32'hC000 + 32'(k));
            chk("bp_level", 32'(fifo_level), 32'(C_DEPTH - 1));
        end
        s_valid  = 1'b0;
        data_req = 1'b0;

        // ---- drain to level 20, then reset mid-frame
        for (int k = 4; k < 15; k++) begin
            req(k + 1, 0);
            chk("drain_pix", 32'(pixel_data), 32'hC000 + 32'(k));
        end
        chk("drain_level", 32'(fifo_level), 32'd20);
        rst = 1'b1;
        #1;
        chk("mrst_pixel", 32'(pixel_data), 32'h0);
        chk("mrst_level", 32'(fifo_level), 32'h0);
        chk("mrst_ready", 32'(s_ready), 32'h0);
        chk("mrst_sync", 32'(sync_lost), 32'h1);
        step();
        rst = 1'b0;
        step();
        for (int i = 0; i < 3; i++) push(16'h1111, 1'b0);
        chk("mrst_pre_level0", 32'(fifo_level), 32'h0);
        push(16'hA5A5, 1'b1);
        chk("mrst_pre_level1", 32'(fifo_level), 32'h1);
        req(0, 0);
        chk("mrst_pix", 32'(pixel_data), 32'hA5A5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
